dct_mac_sched: RTL

Sequencer for the eight-tap multiply-accumulate units inside each `dct_unit` of the `fdct_zigzag.dct_mod` path. It accepts a block of 64 input samples as a handshaked stream, one row of 8 at a time. For each sample it drives the MAC controls: clear, enable and coefficient select. After each row it drains the MAC pipeline, pulses the enable of the `macu.result` register, and then holds a result-valid handshake toward the downstream zig-zag/quantiser stage.

---
 rtl/dct_mac_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dct_mac_sched.sv
// rtl/dct_mac_sched.sv - row sequencer for the eight-tap DCT multiply-accumulate units
module dct_mac_sched #(
    parameter int TAPS    = 8,
    parameter int ROWS    = 8,
    parameter int MAC_LAT = 2,
    localparam int CW     = $clog2(TAPS),
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          din_valid,
    input  logic          din_sof,
    output logic          din_ready,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [CW-1:0] coef_sel,
    output logic [RW-1:0] row_idx,
    output logic          res_en,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          block_done,
    output logic          busy,
    output logic          err_sof
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_CAPT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    drain_q, drain_d;
    logic          res_valid_q, res_valid_d;
    logic          block_done_q, block_done_d;
    logic          err_sof_q, err_sof_d;
    logic          acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            drain_q      <= '0;
            res_valid_q  <= 1'b0;
            block_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            drain_q      <= drain_d;
            res_valid_q  <= res_valid_d;
            block_done_q <= block_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    // Every transition is qualified by ena, either directly or through din_ready.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        drain_d      = drain_q;
        res_valid_d  = res_valid_q;
        block_done_d = 1'b0;
        err_sof_d    = 1'b0;
        din_ready    = 1'b0;
        acc          = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        coef_sel     = cnt_q;
        res_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                din_ready = ena & rst;
                acc       = din_ready & din_valid;
                if (acc && din_sof) begin
                    mac_en   = 1'b1;
                    mac_clr  = 1'b1;
                    coef_sel = '0;
                    cnt_d    = CW'(1);
                    row_d    = '0;
                    state_d  = S_ACC;
                end
            end
            S_ACC: begin
                din_ready = ena & rst;
                acc       = din_ready & din_valid;
                if (acc) begin
                    mac_en = 1'b1;
                    if (din_sof && (row_q != '0 || cnt_q != '0)) begin
                        // Mid-block start of frame: abandon the block and restart it.
                        err_sof_d = 1'b1;
                        mac_clr   = 1'b1;
                        coef_sel  = '0;
                        cnt_d     = CW'(1);
                        row_d     = '0;
                    end else begin
                        mac_clr = (cnt_q == '0);
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CW'(TAPS - 1)) begin
                            drain_d = '0;
                            state_d = (MAC_LAT > 0) ? S_DRAIN : S_CAPT;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (ena) begin
                    if (drain_q == 3'(MAC_LAT - 1)) begin
                        drain_d = '0;
                        state_d = S_CAPT;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            S_CAPT: begin
                res_en = ena;
                if (ena) begin
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ena && res_ready) begin
                    res_valid_d = 1'b0;
                    if (row_q == RW'(ROWS - 1)) begin
                        block_done_d = 1'b1;
                        row_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = S_ACC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign row_idx    = row_q;
    assign res_valid  = res_valid_q;
    assign block_done = block_done_q & ena;
    assign err_sof    = err_sof_q & ena;
    assign busy       = (state_q != S_IDLE);

endmodule
